// File: rtl/alu_sequencer_if.sv
// Command channel into the ALU sequencer: valid/ready handshake carrying {op, operand}.
`timescale 1ns/1ps
interface alu_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OP_W  = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/alu_sequencer.sv
// Command-driven controller for the 4-bit combinational ALU; owns the accumulator and C/Z flags.
// MUL is sequenced as repeated ALU additions of the latched multiplicand.
`timescale 1ns/1ps
module alu_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OP_W  = 3
) (
  input  logic             clock,
  input  logic             reset,
  alu_sequencer_if.slave   cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_c,
  input  logic             alu_z,
  output logic [WIDTH-1:0] acc,
  output logic             flag_c,
  output logic             flag_z,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL_INIT,
    S_MUL_LOOP,
    S_DONE
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = OP_W'(0),
    OP_LIT  = OP_W'(1),
    OP_ADD  = OP_W'(2),
    OP_SUB  = OP_W'(3),
    OP_CMP  = OP_W'(4),
    OP_NAND = OP_W'(5),
    OP_MUL  = OP_W'(6),
    OP_ILL  = OP_W'(7)
  } op_e;

  typedef enum logic [2:0] {
    F_PASS_A = 3'b000,
    F_SUB    = 3'b001,
    F_PASS_B = 3'b010,
    F_ADD    = 3'b011,
    F_NAND   = 3'b100
  } alu_f_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  alu_f_e           f_sel;
  logic             wr_acc;
  logic             wr_flag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOP;
      data_q   <= '0;
      acc_q    <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      z_q      <= z_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    data_d   = data_q;
    acc_d    = acc_q;
    c_d      = c_q;
    z_d      = z_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    f_sel    = F_PASS_A;
    alu_b    = '0;
    wr_acc   = 1'b0;
    wr_flag  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d    = op_e'(cmd.cmd_op);
          data_d  = cmd.cmd_data;
          state_d = (op_e'(cmd.cmd_op) == OP_MUL) ? S_MUL_INIT : S_EXEC;
        end
      end
      S_EXEC: begin
        alu_b = data_q;
        case (op_q)
          OP_LIT:  begin f_sel = F_PASS_B; wr_acc = 1'b1; wr_flag = 1'b1; end
          OP_ADD:  begin f_sel = F_ADD;    wr_acc = 1'b1; wr_flag = 1'b1; end
          OP_SUB:  begin f_sel = F_SUB;    wr_acc = 1'b1; wr_flag = 1'b1; end
          OP_CMP:  begin f_sel = F_SUB;                   wr_flag = 1'b1; end
          OP_NAND: begin f_sel = F_NAND;   wr_acc = 1'b1; wr_flag = 1'b1; end
          default: f_sel = F_PASS_A;
        endcase
        if (wr_acc) acc_d = alu_s;
        if (wr_flag) begin
          c_d = alu_c;
          z_d = alu_z;
        end
        state_d = S_DONE;
      end
      S_MUL_INIT: begin
        f_sel    = F_PASS_B;
        mcand_d  = acc_q;
        cnt_d    = data_q;
        acc_d    = '0;
        sticky_d = 1'b0;
        if (data_q == '0) begin
          c_d     = 1'b0;
          z_d     = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_MUL_LOOP;
        end
      end
      S_MUL_LOOP: begin
        // Final flags fold in this cycle's carry/result since the registers update at the same edge.
        f_sel    = F_ADD;
        alu_b    = mcand_q;
        acc_d    = alu_s;
        sticky_d = sticky_q | alu_c;
        cnt_d    = cnt_q - WIDTH'(1);
        if (cnt_q == WIDTH'(1)) begin
          c_d     = sticky_q | alu_c;
          z_d     = (alu_s == '0);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign alu_f         = f_sel;
  assign alu_a         = acc_q;
  assign acc           = acc_q;
  assign flag_c        = c_q;
  assign flag_z        = z_q;
  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_DONE) && (op_q == OP_ILL);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU, arithmetic reference model, random commands.
`timescale 1ns/1ps
module tb_alu_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alu_a, alu_b, alu_s, acc;
  logic [2:0] alu_f;
  logic       alu_c, alu_z, flag_c, flag_z, busy, done, err;
  logic [4:0] alu_r;

  int errors = 0;
  int checks = 0;
  int m_acc = 0, m_c = 0, m_z = 0;

  always #5 clk = ~clk;

  alu_sequencer_if #(.WIDTH(4), .OP_W(3)) cmd_if ();

  alu_sequencer #(.WIDTH(4), .OP_W(3)) dut (
    .clock (clk),    .reset (rst),    .cmd (cmd_if.slave),
    .alu_a (alu_a),  .alu_b (alu_b),  .alu_f (alu_f),
    .alu_s (alu_s),  .alu_c (alu_c),  .alu_z (alu_z),
    .acc   (acc),    .flag_c(flag_c), .flag_z(flag_z),
    .busy  (busy),   .done  (done),   .err  (err)
  );

  // Combinational ALU: 5-bit result, bit 4 is carry/borrow.
  always_comb begin
    case (alu_f)
      3'b001:  alu_r = {1'b0, alu_a} - {1'b0, alu_b};
      3'b010:  alu_r = {1'b0, alu_b};
      3'b011:  alu_r = {1'b0, alu_a} + {1'b0, alu_b};
      3'b100:  alu_r = {1'b0, ~(alu_a & alu_b)};
      default: alu_r = {1'b0, alu_a};
    endcase
  end
  assign alu_s = alu_r[3:0];
  assign alu_c = alu_r[4];
  assign alu_z = (alu_r[3:0] == 4'd0);

  task automatic model_apply(input int op, input int d, output int lat, output int e);
    int r;
    lat = 2;
    e   = 0;
    case (op)
      1: begin m_acc = d; m_c = 0; m_z = (d == 0); end
      2: begin r = m_acc + d; m_c = (r > 15); m_acc = r % 16; m_z = (m_acc == 0); end
      3: begin m_c = (m_acc < d); m_acc = (m_acc - d + 16) % 16; m_z = (m_acc == 0); end
      4: begin m_c = (m_acc < d); m_z = (m_acc == d); end
      5: begin m_acc = 15 - (m_acc & d); m_c = 0; m_z = (m_acc == 0); end
      6: begin r = m_acc * d; m_c = (r > 15); m_acc = r % 16; m_z = (m_acc == 0); lat = 2 + d; end
      7: e = 1;
      default: ;
    endcase
  endtask

  // Issues one command and observes it to retirement; latency counts the accept cycle as 1.
  task automatic do_cmd(input int op, input int d, output int lat, output int dones,
                        output int errs, output int err_at_done);
    int n;
    lat = 0; dones = 0; errs = 0; err_at_done = 0;
    n = 0;
    @(negedge clk);
    while (cmd_if.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait op=%0d got_ready=%b exp=1", op, cmd_if.cmd_ready);
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'(op);
    cmd_if.cmd_data  = 4'(d);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        dones++;
        if (lat == 0) begin
          lat = i + 1;
          err_at_done = (err === 1'b1) ? 1 : 0;
        end
      end
      if (err === 1'b1) errs++;
      if (cmd_if.cmd_ready === 1'b1) break;
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL retire_timeout op=%0d got_ready=%b exp=1", op, cmd_if.cmd_ready);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (acc !== 4'h0)    begin errors++; $display("FAIL reset_acc got=%h exp=0", acc); end
    checks++; if (flag_c !== 1'b0) begin errors++; $display("FAIL reset_c got=%b exp=0", flag_c); end
    checks++; if (flag_z !== 1'b0) begin errors++; $display("FAIL reset_z got=%b exp=0", flag_z); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      begin errors++; $display("FAIL reset_status got busy/done/err=%b%b%b exp=000", busy, done, err); end
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_if.cmd_ready); end
    checks++; if (alu_f !== 3'b000 || alu_b !== 4'h0)
      begin errors++; $display("FAIL reset_alu got f=%b b=%h exp f=000 b=0", alu_f, alu_b); end
    @(negedge clk);
    rst = 1'b0;
    m_acc = 0; m_c = 0; m_z = 0;
  endtask

  task automatic test_single_step;
    int ops [9] = '{1, 2, 1, 4, 3, 1, 5, 1, 7};
    int dat [9] = '{9, 8, 3, 5, 3, 15, 15, 5, 3};
    int lat, dn, er, ead, elat, eerr;
    for (int i = 0; i < 9; i++) begin
      do_cmd(ops[i], dat[i], lat, dn, er, ead);
      model_apply(ops[i], dat[i], elat, eerr);
      checks++; if (acc !== 4'(m_acc)) begin errors++; $display("FAIL step_acc op=%0d d=%0d got=%h exp=%h", ops[i], dat[i], acc, 4'(m_acc)); end
      checks++; if (flag_c !== 1'(m_c)) begin errors++; $display("FAIL step_c op=%0d d=%0d got=%b exp=%b", ops[i], dat[i], flag_c, 1'(m_c)); end
      checks++; if (flag_z !== 1'(m_z)) begin errors++; $display("FAIL step_z op=%0d d=%0d got=%b exp=%b", ops[i], dat[i], flag_z, 1'(m_z)); end
      checks++; if (dn != 1 || lat != elat) begin errors++; $display("FAIL step_done op=%0d got dones=%0d lat=%0d exp 1/%0d", ops[i], dn, lat, elat); end
      checks++; if (er != eerr || ead != eerr) begin errors++; $display("FAIL step_err op=%0d got errs=%0d at_done=%0d exp=%0d", ops[i], er, ead, eerr); end
    end
  endtask

  task automatic test_mul;
    int ops [7] = '{1, 6, 1, 6, 1, 6, 6};
    int dat [7] = '{3, 5, 6, 3, 7, 0, 9};
    int lat, dn, er, ead, elat, eerr;
    for (int i = 0; i < 7; i++) begin
      do_cmd(ops[i], dat[i], lat, dn, er, ead);
      model_apply(ops[i], dat[i], elat, eerr);
      checks++; if (acc !== 4'(m_acc)) begin errors++; $display("FAIL mul_acc op=%0d d=%0d got=%h exp=%h", ops[i], dat[i], acc, 4'(m_acc)); end
      checks++; if (flag_c !== 1'(m_c)) begin errors++; $display("FAIL mul_c op=%0d d=%0d got=%b exp=%b", ops[i], dat[i], flag_c, 1'(m_c)); end
      checks++; if (flag_z !== 1'(m_z)) begin errors++; $display("FAIL mul_z op=%0d d=%0d got=%b exp=%b", ops[i], dat[i], flag_z, 1'(m_z)); end
      checks++; if (dn != 1 || lat != elat) begin errors++; $display("FAIL mul_latency op=%0d d=%0d got dones=%0d lat=%0d exp 1/%0d", ops[i], dat[i], dn, lat, elat); end
      checks++; if (er != 0) begin errors++; $display("FAIL mul_err got=%0d exp=0", er); end
    end
  endtask

  task automatic test_back_to_back;
    int acc_at [$];
    int done_at [$];
    int lat, e;
    bit accepted;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'd1;
    cmd_if.cmd_data  = 4'hF;
    for (int i = 0; i < 12; i++) begin
      accepted = (cmd_if.cmd_ready === 1'b1) && (cmd_if.cmd_valid === 1'b1);
      if (accepted) acc_at.push_back(i);
      if (done === 1'b1) done_at.push_back(i);
      checks++;
      if (err === 1'b1 && done !== 1'b1) begin errors++; $display("FAIL b2b_err_alone got err=1 done=%b exp err=0", done); end
      @(posedge clk);
      #1;
      if (accepted) begin
        checks++;
        if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_after_accept got=%b exp=0", cmd_if.cmd_ready); end
        if (acc_at.size() == 1) begin cmd_if.cmd_op = 3'd5; cmd_if.cmd_data = 4'hF; end
        else cmd_if.cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
    model_apply(1, 15, lat, e);
    model_apply(5, 15, lat, e);
    checks++;
    if (acc_at.size() != 2 || acc_at[0] != 0 || acc_at[acc_at.size()-1] != 3)
      begin errors++; $display("FAIL b2b_accepts got n=%0d exp 2 at cycles 0,3", acc_at.size()); end
    checks++;
    if (done_at.size() != 2 || done_at[0] != 2 || done_at[done_at.size()-1] != 5)
      begin errors++; $display("FAIL b2b_done_spacing got n=%0d exp 2 at cycles 2,5", done_at.size()); end
    checks++; if (acc !== 4'(m_acc) || flag_z !== 1'(m_z) || flag_c !== 1'(m_c))
      begin errors++; $display("FAIL b2b_result got acc=%h c=%b z=%b exp acc=%h c=%b z=%b", acc, flag_c, flag_z, 4'(m_acc), 1'(m_c), 1'(m_z)); end
  endtask

  task automatic test_random;
    int op, d, lat, dn, er, ead, elat, eerr;
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(7, 0));
      d  = int'($urandom_range(15, 0));
      do_cmd(op, d, lat, dn, er, ead);
      model_apply(op, d, elat, eerr);
      checks++; if (acc !== 4'(m_acc) || flag_c !== 1'(m_c) || flag_z !== 1'(m_z))
        begin errors++; $display("FAIL rand_state op=%0d d=%0d got acc=%h c=%b z=%b exp acc=%h c=%b z=%b", op, d, acc, flag_c, flag_z, 4'(m_acc), 1'(m_c), 1'(m_z)); end
      checks++; if (dn != 1 || lat != elat) begin errors++; $display("FAIL rand_latency op=%0d d=%0d got dones=%0d lat=%0d exp 1/%0d", op, d, dn, lat, elat); end
      checks++; if (er != eerr || ead != eerr) begin errors++; $display("FAIL rand_err op=%0d got errs=%0d at_done=%0d exp=%0d", op, er, ead, eerr); end
      checks++; if (alu_f !== 3'b000 || alu_b !== 4'h0 || alu_a !== 4'(m_acc) || busy !== 1'b0)
        begin errors++; $display("FAIL rand_idle_bus got f=%b b=%h a=%h busy=%b exp f=000 b=0 a=%h busy=0", alu_f, alu_b, alu_a, busy, 4'(m_acc)); end
    end
  endtask

  task automatic test_reset_mid_mul;
    int lat, dn, er, ead, elat, eerr;
    int seen_done;
    do_cmd(1, 3, lat, dn, er, ead);
    model_apply(1, 3, elat, eerr);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'd6;
    cmd_if.cmd_data  = 4'd5;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    m_acc = 0; m_c = 0; m_z = 0;
    checks++; if (acc !== 4'h0 || flag_c !== 1'b0 || flag_z !== 1'b0)
      begin errors++; $display("FAIL midreset_state got acc=%h c=%b z=%b exp 0/0/0", acc, flag_c, flag_z); end
    checks++; if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1)
      begin errors++; $display("FAIL midreset_busy got busy=%b ready=%b exp 0/1", busy, cmd_if.cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL midreset_no_done got=%0d exp=0", seen_done); end
    checks++; if (acc !== 4'h0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_after got acc=%h busy=%b exp 0/0", acc, busy); end
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'd0;
    cmd_if.cmd_data  = 4'd0;
    test_reset();
    test_single_step();
    test_mul();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    test_single_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
